// File: rtl/spi_tx_burst_ctrl_if.sv
// FIFO read port and SPI master TX beat handshake used by spi_tx_burst_ctrl.
// master = the controller side, slave = the FIFO / SPI core side.
interface spi_tx_burst_ctrl_if #(
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned SPI_WIDTH  = 8
);
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_read_data;
  logic                  fifo_read_en;
  logic                  spi_tx_ready;
  logic                  spi_tx_data_valid;
  logic [SPI_WIDTH-1:0]  spi_tx_data;

  modport master (
    input  fifo_empty,
    input  fifo_read_data,
    input  spi_tx_ready,
    output fifo_read_en,
    output spi_tx_data_valid,
    output spi_tx_data
  );

  modport slave (
    output fifo_empty,
    output fifo_read_data,
    output spi_tx_ready,
    input  fifo_read_en,
    input  spi_tx_data_valid,
    input  spi_tx_data
  );
endinterface

// File: rtl/spi_tx_burst_ctrl.sv
// FIFO-to-SPI transmit controller: splits FIFO words into SPI beats and groups
// words into fixed-length or continuous frames, with mid-frame underrun abort.
module spi_tx_burst_ctrl #(
  parameter int unsigned FIFO_WIDTH       = 32,
  parameter int unsigned SPI_WIDTH        = 8,
  parameter int unsigned LEN_W            = 8,
  parameter bit          MSB_FIRST        = 1'b1,
  parameter int unsigned UNDERRUN_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [LEN_W-1:0]       burst_len,
  spi_tx_burst_ctrl_if.master    bus,
  output logic                   frame_active,
  output logic                   frame_done,
  output logic                   underrun_err
);

  localparam int unsigned BEATS  = FIFO_WIDTH / SPI_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned TO_W   = $clog2(UNDERRUN_TIMEOUT + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(UNDERRUN_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND,
    WAIT_DATA,
    END
  } state_t;

  state_t                state;
  logic [FIFO_WIDTH-1:0] shreg;
  logic [FIFO_WIDTH-1:0] shreg_adv;
  logic [BEAT_W-1:0]     beat;
  logic [LEN_W-1:0]      word_cnt;
  logic [LEN_W-1:0]      word_cnt_inc;
  logic [LEN_W-1:0]      len_lat;
  logic [TO_W-1:0]       to_cnt;
  logic [TO_W-1:0]       to_cnt_inc;
  logic                  fixed_mode;

  logic                  read_en_q;
  logic                  valid_q;
  logic [SPI_WIDTH-1:0]  data_q;

  assign bus.fifo_read_en      = read_en_q;
  assign bus.spi_tx_data_valid = valid_q;
  assign bus.spi_tx_data       = data_q;

  // The beat on the wire is always the leading slice of the shift register,
  // so the outgoing order is chosen purely by the shift direction.
  function automatic logic [SPI_WIDTH-1:0] lead_beat(input logic [FIFO_WIDTH-1:0] w);
    if (MSB_FIRST) return w[FIFO_WIDTH-1 -: SPI_WIDTH];
    else           return w[SPI_WIDTH-1:0];
  endfunction

  always_comb begin
    shreg_adv = '0;
    if (MSB_FIRST) shreg_adv = shreg << SPI_WIDTH;
    else           shreg_adv = shreg >> SPI_WIDTH;
  end

  assign word_cnt_inc = word_cnt + LEN_W'(1);
  assign to_cnt_inc   = to_cnt + TO_W'(1);
  assign fixed_mode   = (len_lat != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      beat         <= '0;
      word_cnt     <= '0;
      len_lat      <= '0;
      to_cnt       <= '0;
      read_en_q    <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      read_en_q    <= 1'b0;
      frame_done   <= 1'b0;
      underrun_err <= 1'b0;

      unique case (state)
        IDLE: begin
          if (enable && !bus.fifo_empty) begin
            state        <= FETCH;
            len_lat      <= burst_len;
            word_cnt     <= '0;
            read_en_q    <= 1'b1;
            frame_active <= 1'b1;
          end
        end

        FETCH: begin
          state <= CAPTURE;
        end

        CAPTURE: begin
          shreg   <= bus.fifo_read_data;
          beat    <= '0;
          valid_q <= 1'b1;
          data_q  <= lead_beat(bus.fifo_read_data);
          state   <= SEND;
        end

        SEND: begin
          if (bus.spi_tx_ready) begin
            if (beat != LAST_BEAT) begin
              beat   <= beat + BEAT_W'(1);
              shreg  <= shreg_adv;
              data_q <= lead_beat(shreg_adv);
            end else begin
              valid_q  <= 1'b0;
              data_q   <= '0;
              word_cnt <= word_cnt_inc;
              // Priority: frame length reached, then enable drop, then data.
              if (fixed_mode && (word_cnt_inc == len_lat)) begin
                state      <= END;
                frame_done <= 1'b1;
              end else if (!enable) begin
                state      <= END;
                frame_done <= 1'b1;
              end else if (!bus.fifo_empty) begin
                state     <= FETCH;
                read_en_q <= 1'b1;
              end else if (fixed_mode) begin
                state  <= WAIT_DATA;
                to_cnt <= '0;
              end else begin
                state      <= END;
                frame_done <= 1'b1;
              end
            end
          end
        end

        WAIT_DATA: begin
          if (!bus.fifo_empty) begin
            state     <= FETCH;
            read_en_q <= 1'b1;
          end else if (!enable) begin
            state      <= END;
            frame_done <= 1'b1;
          end else if (to_cnt_inc == TO_LIMIT) begin
            state        <= END;
            frame_done   <= 1'b1;
            underrun_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end

        END: begin
          state        <= IDLE;
          frame_active <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          frame_active <= 1'b0;
          valid_q      <= 1'b0;
          data_q       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_burst_ctrl.sv
// Bench for spi_tx_burst_ctrl: MSB-first and LSB-first instances share one FIFO
// model and run in lockstep; each has its own expected-beat scoreboard.
module tb_spi_tx_burst_ctrl;

  localparam int FW = 32;
  localparam int SW = 8;
  localparam int LW = 8;
  localparam int TO = 16;
  localparam int NB = FW / SW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          fifo_empty = 1'b1;
  logic [FW-1:0] fifo_read_data = '0;
  logic          spi_tx_ready = 1'b0;
  logic          fa0, fd0, ue0, fa1, fd1, ue1;

  spi_tx_burst_ctrl_if #(.FIFO_WIDTH(FW), .SPI_WIDTH(SW)) bus0 ();
  spi_tx_burst_ctrl_if #(.FIFO_WIDTH(FW), .SPI_WIDTH(SW)) bus1 ();

  assign bus0.fifo_empty     = fifo_empty;
  assign bus0.fifo_read_data = fifo_read_data;
  assign bus0.spi_tx_ready   = spi_tx_ready;
  assign bus1.fifo_empty     = fifo_empty;
  assign bus1.fifo_read_data = fifo_read_data;
  assign bus1.spi_tx_ready   = spi_tx_ready;

  spi_tx_burst_ctrl #(
    .FIFO_WIDTH(FW), .SPI_WIDTH(SW), .LEN_W(LW), .MSB_FIRST(1'b1), .UNDERRUN_TIMEOUT(TO)
  ) u_msb (
    .clk(clk), .rst(rst), .enable(enable), .burst_len(burst_len), .bus(bus0.master),
    .frame_active(fa0), .frame_done(fd0), .underrun_err(ue0)
  );

  spi_tx_burst_ctrl #(
    .FIFO_WIDTH(FW), .SPI_WIDTH(SW), .LEN_W(LW), .MSB_FIRST(1'b0), .UNDERRUN_TIMEOUT(TO)
  ) u_lsb (
    .clk(clk), .rst(rst), .enable(enable), .burst_len(burst_len), .bus(bus1.master),
    .frame_active(fa1), .frame_done(fd1), .underrun_err(ue1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_reads, n_beats, n_beats1, n_done, n_und;
  int first_cyc, last_cyc, done_cyc;

  logic [FW-1:0] fifo_q[$];
  logic [SW-1:0] exp0[$];
  logic [SW-1:0] exp1[$];
  logic          hold0 = 1'b0;
  logic [SW-1:0] held0 = '0;

  task automatic clear_counts();
    n_reads = 0; n_beats = 0; n_beats1 = 0; n_done = 0; n_und = 0;
    first_cyc = 0; last_cyc = 0; done_cyc = 0;
  endtask

  task automatic push_word(input logic [FW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
    for (int b = 0; b < NB; b++) begin
      exp0.push_back(SW'(w >> (FW - SW * (b + 1))));
      exp1.push_back(SW'(w >> (SW * b)));
    end
  endtask

  // One clock: observe both DUTs at the falling edge, then advance the FIFO
  // model just after the rising edge (read data valid the cycle after read_en).
  task automatic cycle();
    logic          rd;
    logic [SW-1:0] e;
    rd = 1'b0;
    @(negedge clk);
    if (!rst) begin
      cyc++;
      rd = bus0.fifo_read_en;
      if (bus0.fifo_read_en) begin
        n_reads++;
        checks++;
        if (fifo_empty !== 1'b0 || fa0 !== 1'b1) begin
          errors++;
          $display("FAIL read_pulse: fifo_empty=%b frame_active=%b, required 0 and 1", fifo_empty, fa0);
        end
      end
      if (bus0.fifo_read_en || bus1.fifo_read_en || fd0 || fd1) begin
        checks++;
        if (bus1.fifo_read_en !== bus0.fifo_read_en || fd1 !== fd0) begin
          errors++;
          $display("FAIL lockstep: lsb rd/done=%b%b msb rd/done=%b%b", bus1.fifo_read_en, fd1, bus0.fifo_read_en, fd0);
        end
      end
      if (hold0) begin
        checks++;
        if (bus0.spi_tx_data_valid !== 1'b1 || bus0.spi_tx_data !== held0) begin
          errors++;
          $display("FAIL beat_hold: valid=%b data=%h, required 1 and %h", bus0.spi_tx_data_valid, bus0.spi_tx_data, held0);
        end
      end
      if (!bus0.spi_tx_data_valid) begin
        checks++;
        if (bus0.spi_tx_data !== '0) begin
          errors++;
          $display("FAIL idle_data: data=%h with valid low, required 00", bus0.spi_tx_data);
        end
      end
      if (bus0.spi_tx_data_valid && spi_tx_ready) begin
        checks++;
        if (fa0 !== 1'b1) begin
          errors++;
          $display("FAIL active_in_send: frame_active=%b, required 1", fa0);
        end
        checks++;
        if (exp0.size() == 0) begin
          errors++;
          $display("FAIL msb_beat: got %h, required no beat", bus0.spi_tx_data);
        end else begin
          e = exp0.pop_front();
          if (bus0.spi_tx_data !== e) begin
            errors++;
            $display("FAIL msb_beat: got %h, required %h", bus0.spi_tx_data, e);
          end
        end
        n_beats++;
        if (n_beats == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (bus1.spi_tx_data_valid && spi_tx_ready) begin
        checks++;
        if (exp1.size() == 0) begin
          errors++;
          $display("FAIL lsb_beat: got %h, required no beat", bus1.spi_tx_data);
        end else begin
          e = exp1.pop_front();
          if (bus1.spi_tx_data !== e) begin
            errors++;
            $display("FAIL lsb_beat: got %h, required %h", bus1.spi_tx_data, e);
          end
        end
        n_beats1++;
      end
      hold0 = bus0.spi_tx_data_valid && !spi_tx_ready;
      held0 = bus0.spi_tx_data;
      if (fd0) begin
        n_done++;
        done_cyc = cyc;
        checks++;
        if (fa0 !== 1'b1) begin
          errors++;
          $display("FAIL active_in_end: frame_active=%b, required 1", fa0);
        end
      end
      if (ue0 || ue1) begin
        n_und++;
        checks++;
        if (fd0 !== 1'b1 || ue1 !== ue0) begin
          errors++;
          $display("FAIL underrun_with_done: done=%b ue_msb=%b ue_lsb=%b, required 1 1 1", fd0, ue0, ue1);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) fifo_read_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run_until_done(input int max_cycles);
    for (int i = 0; i < max_cycles && n_done == 0; i++) cycle();
    checks++;
    if (n_done == 0) begin
      errors++;
      $display("FAIL frame_done_timeout: no frame_done within %0d cycles, required one", max_cycles);
    end
  endtask

  task automatic test_reset();
    logic [SW+4:0] obs;
    rst = 1'b1;
    #1;
    obs = {fa0, fd0, ue0, bus0.fifo_read_en, bus0.spi_tx_data_valid, bus0.spi_tx_data};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", obs);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_counts();
    enable = 1'b1;
    repeat (3) cycle();
    checks++;
    if (fa0 !== 1'b0 || n_reads != 0) begin
      errors++;
      $display("FAIL idle_on_empty: frame_active=%b reads=%0d, required 0 and 0", fa0, n_reads);
    end
    enable = 1'b0;
  endtask

  task automatic test_single_word();
    clear_counts();
    burst_len = 8'd1;
    spi_tx_ready = 1'b1;
    push_word(32'hA1B2C3D4);
    enable = 1'b1;
    run_until_done(100);
    cycle();
    checks++;
    if (fa0 !== 1'b0) begin
      errors++;
      $display("FAIL single_active_after_end: frame_active=%b, required 0", fa0);
    end
    checks++;
    if (n_reads != 1 || n_beats != 4 || n_beats1 != 4) begin
      errors++;
      $display("FAIL single_counts: reads=%0d beats=%0d/%0d, required 1 and 4/4", n_reads, n_beats, n_beats1);
    end
    checks++;
    if (last_cyc - first_cyc != 3 || done_cyc - last_cyc != 1) begin
      errors++;
      $display("FAIL single_timing: beat span=%0d done lag=%0d, required 3 and 1", last_cyc - first_cyc, done_cyc - last_cyc);
    end
    checks++;
    if (n_und != 0 || exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL single_leftover: underruns=%0d pending=%0d/%0d, required 0 0/0", n_und, exp0.size(), exp1.size());
    end
    enable = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_ready_toggle();
    clear_counts();
    burst_len = 8'd3;
    spi_tx_ready = 1'b0;
    push_word(32'h01234567);
    push_word(32'h89ABCDEF);
    push_word(32'hDEADBEEF);
    enable = 1'b1;
    for (int i = 0; i < 300 && n_done == 0; i++) begin
      spi_tx_ready = ~spi_tx_ready;
      cycle();
    end
    spi_tx_ready = 1'b1;
    repeat (5) cycle();
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL toggle_done: frame_done pulses=%0d, required 1", n_done);
    end
    checks++;
    if (n_reads != 3 || n_beats != 12 || n_beats1 != 12) begin
      errors++;
      $display("FAIL toggle_counts: reads=%0d beats=%0d/%0d, required 3 and 12/12", n_reads, n_beats, n_beats1);
    end
    checks++;
    if (n_und != 0 || exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL toggle_leftover: underruns=%0d pending=%0d/%0d, required 0 0/0", n_und, exp0.size(), exp1.size());
    end
    enable = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_underrun();
    clear_counts();
    burst_len = 8'd4;
    spi_tx_ready = 1'b1;
    push_word(32'h11223344);
    push_word(32'h55667788);
    enable = 1'b1;
    run_until_done(200);
    cycle();
    checks++;
    if (n_und != 1 || fa0 !== 1'b0) begin
      errors++;
      $display("FAIL underrun_pulse: underruns=%0d frame_active=%b, required 1 and 0", n_und, fa0);
    end
    checks++;
    if (done_cyc - last_cyc != TO + 1) begin
      errors++;
      $display("FAIL underrun_wait: done lag=%0d, required %0d", done_cyc - last_cyc, TO + 1);
    end
    checks++;
    if (n_reads != 2 || n_beats != 8 || exp0.size() != 0) begin
      errors++;
      $display("FAIL underrun_counts: reads=%0d beats=%0d pending=%0d, required 2 8 0", n_reads, n_beats, exp0.size());
    end
    enable = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_continuous();
    clear_counts();
    burst_len = '0;
    spi_tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(FW'($urandom));
    enable = 1'b1;
    run_until_done(300);
    repeat (3) cycle();
    checks++;
    if (n_done != 1 || n_und != 0) begin
      errors++;
      $display("FAIL cont_done: frame_done=%0d underruns=%0d, required 1 and 0", n_done, n_und);
    end
    checks++;
    if (n_reads != 5 || n_beats != 20 || n_beats1 != 20) begin
      errors++;
      $display("FAIL cont_counts: reads=%0d beats=%0d/%0d, required 5 and 20/20", n_reads, n_beats, n_beats1);
    end
    checks++;
    if (last_cyc - first_cyc != 27) begin
      errors++;
      $display("FAIL cont_throughput: beat span=%0d, required 27", last_cyc - first_cyc);
    end
    enable = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_reset_midframe();
    logic [2*SW+9:0] obs;
    clear_counts();
    burst_len = 8'd1;
    spi_tx_ready = 1'b1;
    push_word(32'hCAFEF00D);
    enable = 1'b1;
    for (int i = 0; i < 50 && n_beats == 0; i++) cycle();
    checks++;
    if (bus0.spi_tx_data_valid !== 1'b1 || bus0.spi_tx_data !== 8'hFE) begin
      errors++;
      $display("FAIL mid_second_beat: valid=%b data=%h, required 1 and fe", bus0.spi_tx_data_valid, bus0.spi_tx_data);
    end
    rst = 1'b1;
    #1;
    obs = {fa0, fd0, ue0, bus0.fifo_read_en, bus0.spi_tx_data_valid, bus0.spi_tx_data,
           fa1, fd1, ue1, bus1.fifo_read_en, bus1.spi_tx_data_valid, bus1.spi_tx_data};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h, required 0", obs);
    end
    repeat (2) @(posedge clk);
    #1;
    exp0.delete();
    exp1.delete();
    hold0 = 1'b0;
    rst = 1'b0;
    repeat (10) cycle();
    checks++;
    if (n_beats != 1 || n_done != 0 || n_reads != 1 || fa0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_resume: beats=%0d done=%0d reads=%0d active=%b, required 1 0 1 0", n_beats, n_done, n_reads, fa0);
    end
    enable = 1'b0;
  endtask

  initial begin
    clear_counts();
    #2;
    test_reset();
    test_single_word();
    test_ready_toggle();
    test_underrun();
    test_continuous();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
